bounce_generator: RTL and testbench

Synthesizable contact-bounce emulator: drives a single output that moves to a requested logic level through a pseudo-random train of short glitches, then settles cleanly. It is the source-side counterpart of the debouncer. It feeds the debouncer's noisy input in self-test and FPGA loopback builds, giving a repeatable, cycle-exact noisy stimulus with guaranteed maximum glitch width.

---
 rtl/bounce_pkg.sv | 17 +
 rtl/bounce_generator_lfsr16.sv | 21 ++
 rtl/bounce_generator.sv | 106 ++++++++++
 tb/tb_bounce_generator.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/bounce_pkg.sv
// Shared types and constants for the contact-bounce emulator.
package bounce_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    BOUNCE = 1'b1
  } state_t;

  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  // One right-shifting Galois step: feedback from bit 0 into the tap positions.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    lfsr_step = s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

endpackage

// File: rtl/bounce_generator_lfsr16.sv
// 16-bit Galois LFSR; advances only when enabled, reloads the seed on reset.
module lfsr16
  import bounce_pkg::*;
#(
  parameter logic [15:0] SEED = DEFAULT_SEED
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_en,
  output logic [15:0] o_state
);

  // An all-zero state would lock the register up, so swap in a legal seed.
  localparam logic [15:0] SEED_SAFE = (SEED == 16'h0000) ? 16'h0001 : SEED;

  always_ff @(posedge i_clk) begin
    if (i_rst)     o_state <= SEED_SAFE;
    else if (i_en) o_state <= lfsr_step(o_state);
  end

endmodule

// File: rtl/bounce_generator.sv
// Contact-bounce emulator: walks o_out to a requested level through a
// pseudo-random glitch train with bounded run length, then settles cleanly.
module bounce_generator
  import bounce_pkg::*;
#(
  parameter int          RUN_W = 2,
  parameter int          LEN_W = 8,
  parameter logic [15:0] SEED  = DEFAULT_SEED
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  input  logic             i_level,
  input  logic [LEN_W-1:0] i_bounce_len,
  output logic             o_ready,
  output logic             o_busy,
  output logic             o_out,
  output logic             o_settled
);

  state_t           state, state_nx;
  logic [LEN_W-1:0] remaining, remaining_nx;
  logic [RUN_W-1:0] run, run_nx;
  logic             level, level_nx;
  logic             out_nx, settled_nx;
  logic [15:0]      lfsr;
  logic [RUN_W-1:0] run_seed;
  logic             unused_lfsr_hi;

  lfsr16 #(.SEED(SEED)) u_lfsr (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_en    (state == BOUNCE),
    .o_state (lfsr)
  );

  // A zero run would never expire, so it is promoted to the shortest run.
  assign run_seed       = (lfsr[RUN_W-1:0] == '0) ? RUN_W'(1) : lfsr[RUN_W-1:0];
  assign unused_lfsr_hi = ^lfsr[15:RUN_W];

  always_comb begin
    state_nx     = state;
    remaining_nx = remaining;
    run_nx       = run;
    level_nx     = level;
    out_nx       = o_out;
    settled_nx   = 1'b0;
    case (state)
      IDLE: begin
        if (i_valid) begin
          if (i_level == o_out) begin
            settled_nx = 1'b1;
          end else if (i_bounce_len == '0) begin
            out_nx     = i_level;
            settled_nx = 1'b1;
          end else begin
            level_nx     = i_level;
            out_nx       = i_level;
            remaining_nx = i_bounce_len - LEN_W'(1);
            run_nx       = run_seed;
            state_nx     = BOUNCE;
          end
        end
      end
      BOUNCE: begin
        // Settling wins over a toggle that would land on the same edge.
        if (remaining == '0) begin
          out_nx     = level;
          settled_nx = 1'b1;
          state_nx   = IDLE;
        end else begin
          remaining_nx = remaining - LEN_W'(1);
          if (run <= RUN_W'(1)) begin
            out_nx = ~o_out;
            run_nx = run_seed;
          end else begin
            run_nx = run - RUN_W'(1);
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= IDLE;
      remaining <= '0;
      run       <= '0;
      level     <= 1'b0;
      o_out     <= 1'b0;
      o_settled <= 1'b0;
    end else begin
      state     <= state_nx;
      remaining <= remaining_nx;
      run       <= run_nx;
      level     <= level_nx;
      o_out     <= out_nx;
      o_settled <= settled_nx;
    end
  end

  assign o_ready = (state == IDLE);
  assign o_busy  = (state == BOUNCE);

endmodule

// File: tb/tb_bounce_generator.sv
// Bench for bounce_generator: directed scenarios plus random traffic, all
// checked every cycle against a request-level waveform model.
module tb_bounce_generator;

  logic       i_clk = 1'b0;
  logic       i_rst, i_valid, i_level;
  logic [7:0] i_bounce_len;
  logic       o_ready, o_busy, o_out, o_settled;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  bounce_generator dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_level(i_level),
    .i_bounce_len(i_bounce_len), .o_ready(o_ready), .o_busy(o_busy),
    .o_out(o_out), .o_settled(o_settled)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [15:0] adv(input logic [15:0] s);
    adv = s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  function automatic int runlen(input logic [15:0] s);
    runlen = (s[1:0] == 2'd0) ? 1 : int'(s[1:0]);
  endfunction

  typedef struct packed {logic busy; logic out; logic settled;} exp_t;
  exp_t        q[$];
  logic [15:0] m_lfsr    = 16'hACE1;
  logic        m_out     = 1'b0;
  logic        m_busy    = 1'b0;
  logic        m_settled = 1'b0;

  // A whole bounce is expanded up front: segment lengths come from the LFSR
  // sequence, each segment's length taken from the value one cycle before it starts.
  always @(posedge i_clk) begin
    exp_t e;
    if (i_rst) begin
      q.delete();
      m_lfsr = 16'hACE1; m_out = 1'b0; m_busy = 1'b0; m_settled = 1'b0;
    end else if (q.size() > 0) begin
      e = q.pop_front();
      m_busy = e.busy; m_out = e.out; m_settled = e.settled;
    end else begin
      m_settled = 1'b0;
      if (i_valid) begin
        if (i_level == m_out) m_settled = 1'b1;
        else if (i_bounce_len == 8'd0) begin
          m_out = i_level; m_settled = 1'b1;
        end else begin
          logic [15:0] lf;
          logic        cur;
          int          nxt;
          lf  = m_lfsr;
          cur = i_level;
          nxt = runlen(lf);
          q.push_back('{1'b1, cur, 1'b0});
          for (int k = 1; k < int'(i_bounce_len); k++) begin
            if (k == nxt) begin
              cur = ~cur;
              nxt = k + runlen(lf);
            end
            q.push_back('{1'b1, cur, 1'b0});
            lf = adv(lf);
          end
          m_lfsr = adv(lf);
          q.push_back('{1'b0, i_level, 1'b1});
          e = q.pop_front();
          m_busy = e.busy; m_out = e.out; m_settled = e.settled;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  logic prev_out = 1'b0, was_busy = 1'b0;
  int   hold     = 0;
  always @(negedge i_clk) begin
    if (chk_en) begin
      chk("out", o_out, m_out);
      chk("busy", o_busy, m_busy);
      chk("ready", o_ready, !m_busy);
      chk("settled", o_settled, m_settled);
      if (o_busy) begin
        hold = (was_busy && o_out == prev_out) ? hold + 1 : 1;
        chk("max_run_le_3", hold <= 3, 1);
      end
    end
    prev_out = o_out;
    was_busy = o_busy;
  end

  // ---------------- stimulus ----------------
  task automatic req(input logic lvl, input logic [7:0] len);
    i_valid = 1'b1; i_level = lvl; i_bounce_len = len;
    @(negedge i_clk);
    i_valid = 1'b0;
  endtask

  task automatic pulse_rst();
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
  endtask

  // Samples o_out during the bounce; returns at the first non-busy negedge.
  task automatic record(output logic [63:0] w, output int n);
    w = '0; n = 0;
    while (o_busy && n < 64) begin
      w[n] = o_out; n++;
      @(negedge i_clk);
    end
    if (o_busy) chk("busy_timeout", 1, 0);
  endtask

  initial begin
    logic [63:0] wa, wb;
    int          na, nb, nset;
    i_rst = 1'b1; i_valid = 1'b0; i_level = 1'b0; i_bounce_len = 8'd0;
    chk("lfsr_step_ace1", adv(16'hACE1), 16'hE270);
    repeat (2) @(negedge i_clk);
    chk_en = 1'b1;

    // reset held for three cycles
    for (int i = 0; i < 3; i++) begin
      chk("rst_out", o_out, 0); chk("rst_ready", o_ready, 1);
      chk("rst_busy", o_busy, 0); chk("rst_settled", o_settled, 0);
      @(negedge i_clk);
    end
    i_rst = 1'b0;
    @(negedge i_clk);

    // zero-length toggle
    req(1'b1, 8'd0);
    chk("len0_out", o_out, 1); chk("len0_settled", o_settled, 1); chk("len0_busy", o_busy, 0);
    @(negedge i_clk);
    chk("len0_settle_once", o_settled, 0);

    // 20-cycle bounce to 0 from the reset seed
    req(1'b0, 8'd20);
    chk("b20_first", o_out, 0);
    record(wa, na);
    chk("b20_busy_cycles", na, 20);
    chk("b20_pattern_head", wa[4:0], 5'b01010);
    chk("b20_final_out", o_out, 0); chk("b20_settled", o_settled, 1);
    repeat (3) @(negedge i_clk);
    chk("b20_stable", o_out, 0);

    // request equal to the current level
    req(1'b0, 8'd50);
    chk("same_busy", o_busy, 0); chk("same_settled", o_settled, 1); chk("same_out", o_out, 0);

    // conflicting request while busy is dropped
    nset = 0;
    req(1'b1, 8'd10);
    for (int i = 0; i < 14; i++) begin
      i_valid = (i >= 2 && i < 5); i_level = 1'b0; i_bounce_len = 8'd3;
      if (o_settled) nset++;
      @(negedge i_clk);
    end
    i_valid = 1'b0;
    chk("ignore_final_out", o_out, 1); chk("ignore_one_settle", nset, 1);

    // reset mid-bounce, then reseeded rerun must repeat the pattern
    pulse_rst();
    req(1'b1, 8'd30);
    record(wa, na);
    chk("b30_busy_cycles", na, 30);
    pulse_rst();
    req(1'b1, 8'd30);
    repeat (5) @(negedge i_clk);
    i_rst = 1'b1;
    @(negedge i_clk);
    chk("midrst_out", o_out, 0); chk("midrst_ready", o_ready, 1);
    chk("midrst_settled", o_settled, 0);
    i_rst = 1'b0;
    @(negedge i_clk);
    chk("midrst_no_settle", o_settled, 0);
    req(1'b1, 8'd30);
    record(wb, nb);
    chk("rerun_len", nb, 30);
    chk("rerun_pattern", wb[31:0], wa[31:0]);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      i_valid      = ($urandom_range(0, 2) == 0);
      i_level      = 1'($urandom_range(0, 1));
      i_bounce_len = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 40));
      i_rst        = ($urandom_range(0, 149) == 0);
      @(negedge i_clk);
    end
    i_valid = 1'b0; i_rst = 1'b0;
    repeat (50) @(negedge i_clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
